// File: rtl/md_pkg.sv
// md_pkg: op codes and FSM state encoding shared by the multiply/divide unit
package md_pkg;
    localparam logic [3:0] MD_NOP   = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;
    localparam logic [3:0] MD_MFHI  = 4'd7;
    localparam logic [3:0] MD_MFLO  = 4'd8;
    typedef enum logic {MD_IDLE = 1'b0, MD_RUN = 1'b1} md_state_e;
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational multiply/divide datapath producing {hi, lo, div_by_zero}
//   op          in   4      md op code (only MULT/MULTU/DIV/DIVU are meaningful)
//   a, b        in   WIDTH  rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi, lo      out  WIDTH  product halves, or remainder/quotient
//   div_by_zero out  1      divide op with b == 0
module md_calc import md_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);
    logic sgn, is_div, an, bn;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] am, bm, q, r, quo, rem;
    assign sgn = op == MD_MULT || op == MD_DIV;
    assign is_div = op == MD_DIV || op == MD_DIVU;
    // Extending both operands to 2*WIDTH lets one truncated multiply serve signed and unsigned
    assign prod = {{WIDTH{sgn & a[WIDTH-1]}}, a} * {{WIDTH{sgn & b[WIDTH-1]}}, b};
    // Signed divide runs on magnitudes, so MIN / -1 wraps back to MIN without a trap
    assign an = sgn & a[WIDTH-1];
    assign bn = sgn & b[WIDTH-1];
    assign div_by_zero = is_div && b == '0;
    assign am = an ? -a : a;
    assign bm = div_by_zero ? WIDTH'(1) : bn ? -b : b;
    assign q = am / bm;
    assign r = am % bm;
    assign quo = (an ^ bn) ? -q : q;
    assign rem = an ? -r : r;
    assign hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
    assign lo = is_div ? quo : prod[WIDTH-1:0];
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit holding HI/LO
//   clk, reset   in   1      rising-edge clock, async active-high reset
//   md_op        in   4      E-stage op (NOP/MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO)
//   rs_val       in   WIDTH  rs operand / MT source
//   rt_val       in   WIDTH  rt operand
//   busy         out  1      op in flight
//   hi, lo       out  WIDTH  committed HI/LO
//   md_out       out  WIDTH  MFHI/MFLO read data, else 0
module md_unit import md_pkg::*; #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       md_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_out
);
    localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
    md_state_e state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] pend_hi, pend_lo, calc_hi, calc_lo;
    logic dz, start, done, idle;
    md_calc #(.WIDTH(WIDTH)) u_calc (
        .op          (md_op),
        .a           (rs_val),
        .b           (rt_val),
        .hi          (calc_hi),
        .lo          (calc_lo),
        .div_by_zero (dz)
    );
    assign idle = state == MD_IDLE;
    assign start = idle && md_op >= MD_MULT && md_op <= MD_DIVU;
    assign done = state == MD_RUN && cnt == CW'(1);
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= MD_IDLE;
        else state <= state_nx;
    always_comb state_nx = start ? MD_RUN : done ? MD_IDLE : state;
    always_comb md_out = md_op == MD_MFHI ? hi : md_op == MD_MFLO ? lo : '0;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            busy <= state_nx == MD_RUN;
            if (start) begin
                // Divide by zero re-commits the current HI/LO, which RUN cannot change meanwhile
                pend_hi <= dz ? hi : calc_hi;
                pend_lo <= dz ? lo : calc_lo;
                cnt     <= md_op <= MD_MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (!idle) begin
                cnt <= cnt - CW'(1);
            end
            if (done) begin
                hi <= pend_hi;
                lo <= pend_lo;
            end else if (idle && md_op == MD_MTHI) begin
                hi <= rs_val;
            end else if (idle && md_op == MD_MTLO) begin
                lo <= rs_val;
            end
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: scoreboard bench for md_unit against a longint reference model
module tb_md_unit;
    import md_pkg::*;
    typedef struct {
        int          cyc;
        bit          is_out;
        logic        busy;
        logic [31:0] hi;
        logic [31:0] lo;
    } ent_t;
    logic clk = 1'b0, reset = 1'b1, busy;
    logic [3:0] md_op = MD_NOP;
    logic [31:0] rs_val = '0, rt_val = '0, hi, lo, md_out;
    logic [31:0] m_hi = '0, m_lo = '0;
    int cyc = 0, n_chk = 0, n_fail = 0;
    ent_t sb[$];
    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic logic [63:0] ref_md(input logic [3:0] op, input logic [31:0] a, b, h, l);
        longint sa, sb2, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == MD_MULT) begin
            q = sa * sb2;
            return q;
        end
        if (op == MD_MULTU) return ua * ub;
        if (b == 0) return {h, l};
        if (op == MD_DIV) begin
            q = sa / sb2;
            r = sa % sb2;
            return {r[31:0], q[31:0]};
        end
        p = ua % ub;
        q = longint'(ua / ub);
        return {p[31:0], q[31:0]};
    endfunction
    function automatic void push(input int c, input bit o, input logic b, input logic [31:0] h, l);
        ent_t e;
        e.cyc = c; e.is_out = o; e.busy = b; e.hi = h; e.lo = l;
        sb.push_back(e);
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 9));
            4: return -32'($urandom_range(1, 9));
            default: return $urandom();
        endcase
    endfunction
    task automatic check_now(input string name, input logic [95:0] got, exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask
    initial forever begin
        ent_t e;
        @(negedge clk);
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            if (e.cyc != cyc) begin
                n_fail++;
                $display("FAIL late_entry cyc=%0d expected_cyc=%0d", cyc, e.cyc);
            end else if (e.is_out) begin
                if (md_out !== e.hi) begin
                    n_fail++;
                    $display("FAIL md_out cyc=%0d got=%h expected=%h", cyc, md_out, e.hi);
                end
            end else if ({busy, hi, lo} !== {e.busy, e.hi, e.lo}) begin
                n_fail++;
                $display("FAIL state cyc=%0d got busy=%0b hi=%h lo=%h expected busy=%0b hi=%h lo=%h",
                         cyc, busy, hi, lo, e.busy, e.hi, e.lo);
            end
        end
    end
    task automatic issue(input logic [3:0] op, input logic [31:0] a, b, input bit directed);
        logic [63:0] r;
        int n;
        @(negedge clk);
        #1;
        md_op = op; rs_val = a; rt_val = b;
        if (op >= MD_MULT && op <= MD_DIVU) begin
            r = ref_md(op, a, b, m_hi, m_lo);
            n = op <= MD_MULTU ? 5 : 10;
            push(cyc + 1, 1'b0, 1'b1, m_hi, m_lo);
            for (int i = 1; i <= n; i++) begin
                @(negedge clk);
                #1;
                if (directed) md_op = i == 1 ? MD_MULT : i == 2 ? MD_MTLO : i == 3 ? MD_MFLO : MD_NOP;
                else md_op = 4'($urandom_range(0, 15));
                rs_val = $urandom();
                rt_val = $urandom();
                if (md_op == MD_MFHI) push(cyc, 1'b1, 1'b0, m_hi, 32'h0);
                if (md_op == MD_MFLO) push(cyc, 1'b1, 1'b0, m_lo, 32'h0);
            end
            push(cyc + 1, 1'b0, 1'b0, r[63:32], r[31:0]);
            m_hi = r[63:32];
            m_lo = r[31:0];
        end else begin
            if (op == MD_MFHI) push(cyc, 1'b1, 1'b0, m_hi, 32'h0);
            else if (op == MD_MFLO) push(cyc, 1'b1, 1'b0, m_lo, 32'h0);
            else if (op == MD_NOP || op > MD_MFLO) push(cyc, 1'b1, 1'b0, 32'h0, 32'h0);
            if (op == MD_MTHI) m_hi = a;
            if (op == MD_MTLO) m_lo = a;
            push(cyc + 1, 1'b0, 1'b0, m_hi, m_lo);
        end
    endtask
    initial begin
        repeat (3) @(negedge clk);
        #1;
        md_op = MD_MFHI;
        check_now("reset_state", {31'b0, busy, hi, lo, md_out}, 96'h0);
        reset = 1'b0;
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
        issue(MD_DIVU, 32'd7, 32'd2, 1'b0);
        issue(MD_DIV, -32'd7, 32'd2, 1'b0);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        issue(MD_MTHI, 32'h1234, 32'h0, 1'b0);
        issue(MD_DIV, 32'd55, 32'd0, 1'b0);
        issue(MD_MFHI, 32'h0, 32'h0, 1'b0);
        issue(MD_MTLO, 32'hCAFE, 32'h0, 1'b0);
        issue(MD_DIV, 32'd100, 32'd7, 1'b1);
        issue(MD_MFLO, 32'h0, 32'h0, 1'b0);
        issue(MD_NOP, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        md_op = MD_MULT; rs_val = 32'h1234_5678; rt_val = 32'h9ABC_DEF0;
        push(cyc + 1, 1'b0, 1'b1, m_hi, m_lo);
        repeat (2) begin
            @(negedge clk);
            #1;
            md_op = MD_NOP;
        end
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_now("reset_midflight", {31'b0, busy, hi, lo, 32'h0}, 96'h0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        #1;
        check_now("reset_held", {31'b0, busy, hi, lo, 32'h0}, 96'h0);
        reset = 1'b0;
        issue(MD_MULT, 32'hFFFF_FFF9, 32'h0000_0006, 1'b0);
        for (int k = 0; k < 160; k++) issue(4'($urandom_range(1, 15)), pick(), pick(), 1'b0);
        issue(MD_NOP, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        #3;
        check_now("scoreboard_empty", 96'(sb.size()), 96'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
